hdu_sb: RTL and testbench

- Parametrised hazard detection unit for the in-order core.
- Replaces the purely combinational stall/flush logic with three pieces:
  - a register scoreboard for long-latency results (loads, mul/div);
  - a structural outstanding-op limit;
  - a CSR serialisation FSM.
- Emits per-pipeline-register stall/flush vectors sized by NUM_STAGES, so deeper pipelines reuse the block unchanged.

---
 rtl/hdu_pkg.sv | 26 ++
 rtl/hdu_sb_if.sv | 40 ++++
 rtl/hdu_scoreboard.sv | 74 +++++++
 rtl/hdu_sb.sv | 120 ++++++++++++
 tb/tb_hdu_sb.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hdu_pkg.sv
// Shared definitions for the hazard detection unit: stage indices, CSR
// serialisation states and a stage-mask helper.
package hdu_pkg;

    localparam int IF_S       = 0;
    localparam int ID_S       = 1;
    localparam int EX_S       = 2;
    localparam int MEM_S      = 3;
    localparam int WB_S       = 4;
    localparam int MAX_STAGES = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } csr_state_t;

    // Mask with a one in every stage index strictly below n.
    function automatic logic [MAX_STAGES-1:0] below_mask(input int n);
        logic [MAX_STAGES-1:0] m;
        for (int i = 0; i < MAX_STAGES; i++) begin
            m[i] = (i < n) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/hdu_sb_if.sv
// Pipeline-side bundle of the hazard detection unit: ID-stage decode info,
// writeback/retire/redirect events in, stall/flush controls out.
interface hdu_sb_if #(
    parameter int NUM_STAGES = 5,
    parameter int NREG       = 32,
    parameter int RAW        = 5
);
    logic                  id_valid;
    logic [RAW-1:0]        id_rs1;
    logic [RAW-1:0]        id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [RAW-1:0]        id_rd;
    logic                  id_rd_write;
    logic                  id_long_lat;
    logic                  id_csr;
    logic                  lat_done;
    logic [RAW-1:0]        lat_rd;
    logic                  csr_retire;
    logic                  branch_take;
    logic                  trap_take;
    logic [NUM_STAGES-1:0] stage_stall;
    logic [NUM_STAGES-1:0] stage_flush;
    logic                  lu_kill;
    logic [NREG-1:0]       sb_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rd_write, id_long_lat, id_csr, lat_done, lat_rd,
               csr_retire, branch_take, trap_take,
        input  stage_stall, stage_flush, lu_kill, sb_busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rd_write, id_long_lat, id_csr, lat_done, lat_rd,
               csr_retire, branch_take, trap_take,
        output stage_stall, stage_flush, lu_kill, sb_busy
    );
endinterface

// File: rtl/hdu_scoreboard.sv
// Busy bits for registers awaiting a long-latency writeback, plus the count
// of outstanding long-latency ops used for the structural limit.
module hdu_scoreboard #(
    parameter int NREG     = 32,
    parameter int RAW      = 5,
    parameter int LU_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_kill,
    input  logic            i_issue_long,
    input  logic            i_set_en,
    input  logic [RAW-1:0]  i_set_rd,
    input  logic            i_clr_en,
    input  logic [RAW-1:0]  i_clr_rd,
    output logic [NREG-1:0] o_busy,
    output logic            o_count_zero,
    output logic            o_count_full
);
    localparam int CW = $clog2(LU_DEPTH + 1);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            w_dec;

    // Next busy vector and count; a set beats a clear of the same register.
    always_comb begin
        w_set_vec    = '0;
        w_clr_vec    = '0;
        w_count_next = r_count;
        w_dec        = i_clr_en & (r_count != '0);
        if (i_set_en && (i_set_rd != '0)) begin
            w_set_vec = NREG'(1) << i_set_rd;
        end else begin
            w_set_vec = '0;
        end
        if (i_clr_en) begin
            w_clr_vec = NREG'(1) << i_clr_rd;
        end else begin
            w_clr_vec = '0;
        end
        w_busy_next = (r_busy & ~w_clr_vec) | w_set_vec;
        if (i_issue_long && !w_dec && (r_count != CW'(LU_DEPTH))) begin
            w_count_next = r_count + CW'(1);
        end else if (!i_issue_long && w_dec) begin
            w_count_next = r_count - CW'(1);
        end else begin
            w_count_next = r_count;
        end
    end

    // State registers; a trap discards every in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else if (i_kill) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_count <= w_count_next;
        end
    end

    assign o_busy       = r_busy;
    assign o_count_zero = (r_count == '0);
    assign o_count_full = (r_count == CW'(LU_DEPTH));

endmodule

// File: rtl/hdu_sb.sv
// Hazard detection unit: scoreboard-based RAW/WAW checks, outstanding-op
// limit and CSR serialisation, driving per-stage stall/flush vectors.
module hdu_sb
    import hdu_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int ID_STAGE     = ID_S,
    parameter int BRANCH_STAGE = EX_S,
    parameter int NREG         = 32,
    parameter int RAW          = 5,
    parameter int LU_DEPTH     = 2
) (
    input  logic     clk,
    input  logic     rst,
    hdu_sb_if.slave  bus
);
    localparam logic [NUM_STAGES-1:0] BR_MASK  = NUM_STAGES'(below_mask(BRANCH_STAGE));
    localparam logic [NUM_STAGES-1:0] ID_BELOW = NUM_STAGES'(below_mask(ID_STAGE));
    localparam logic [NUM_STAGES-1:0] ID_BIT   = NUM_STAGES'(1) << ID_STAGE;

    if ((RAW != $clog2(NREG)) || (LU_DEPTH < 1) || (LU_DEPTH > NREG - 1)
        || (ID_STAGE >= NUM_STAGES) || (BRANCH_STAGE >= NUM_STAGES)) begin : g_bad_param
        $error("hdu_sb: inconsistent parameters");
    end

    logic [NREG-1:0]       w_busy;
    logic [NREG-1:0]       w_clr_vec;
    logic [NREG-1:0]       w_avail;
    logic                  w_count_zero;
    logic                  w_count_full;
    logic                  w_data_haz;
    logic                  w_struct_haz;
    logic                  w_csr_haz;
    logic                  w_hold;
    logic                  w_issue;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;
    logic                  w_kill;
    csr_state_t            r_csr_state;
    csr_state_t            w_csr_next;

    // Same-cycle writebacks are forwarded, so they count as available.
    assign w_clr_vec = bus.lat_done ? (NREG'(1) << bus.lat_rd) : '0;
    assign w_avail   = ~w_busy | w_clr_vec;

    assign w_data_haz = bus.id_valid &
                        ((bus.id_rs1_used & ~w_avail[bus.id_rs1]) |
                         (bus.id_rs2_used & ~w_avail[bus.id_rs2]) |
                         (bus.id_rd_write & ~w_avail[bus.id_rd]));
    assign w_struct_haz = bus.id_valid & bus.id_long_lat & w_count_full & ~bus.lat_done;
    assign w_csr_haz    = (r_csr_state == DRAIN) | (bus.id_valid & bus.id_csr & ~w_count_zero);
    assign w_hold       = w_data_haz | w_struct_haz | w_csr_haz;
    assign w_issue      = bus.id_valid & ~w_hold & ~bus.branch_take & ~bus.trap_take;

    hdu_scoreboard #(
        .NREG     (NREG),
        .RAW      (RAW),
        .LU_DEPTH (LU_DEPTH)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_kill       (bus.trap_take),
        .i_issue_long (w_issue & bus.id_long_lat),
        .i_set_en     (w_issue & bus.id_long_lat & bus.id_rd_write),
        .i_set_rd     (bus.id_rd),
        .i_clr_en     (bus.lat_done),
        .i_clr_rd     (bus.lat_rd),
        .o_busy       (w_busy),
        .o_count_zero (w_count_zero),
        .o_count_full (w_count_full)
    );

    // CSR serialisation next state; a retire seen while idle is ignored.
    always_comb begin
        w_csr_next = r_csr_state;
        case (r_csr_state)
            IDLE:    w_csr_next = (w_issue & bus.id_csr) ? DRAIN : IDLE;
            DRAIN:   w_csr_next = bus.csr_retire ? IDLE : DRAIN;
            default: w_csr_next = IDLE;
        endcase
    end

    // CSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csr_state <= IDLE;
        end else if (bus.trap_take) begin
            r_csr_state <= IDLE;
        end else begin
            r_csr_state <= w_csr_next;
        end
    end

    // Stall/flush priority: reset, trap, branch, hazard hold.
    always_comb begin
        w_stall = '0;
        w_flush = '0;
        w_kill  = 1'b0;
        if (rst) begin
            w_flush = '1;
        end else if (bus.trap_take) begin
            w_flush = '1;
            w_kill  = 1'b1;
        end else if (bus.branch_take) begin
            w_flush = BR_MASK;
        end else if (w_hold) begin
            w_stall = ID_BELOW;
            w_flush = ID_BIT;
        end else begin
            w_stall = '0;
            w_flush = '0;
        end
    end

    assign bus.stage_stall = w_stall;
    assign bus.stage_flush = w_flush;
    assign bus.lu_kill     = w_kill;
    assign bus.sb_busy     = w_busy;

endmodule

// File: tb/tb_hdu_sb.sv
// Bench for hdu_sb: directed table of corner-case sequences, then randomised
// traffic checked against a reference model of the hazard rules.
module tb_hdu_sb;
    localparam int NS = 5;
    localparam int NR = 32;
    localparam int RW = 5;
    localparam int LD = 2;

    localparam int RST  = 1;
    localparam int VAL  = 2;
    localparam int U1   = 4;
    localparam int WR   = 8;
    localparam int LNG  = 16;
    localparam int CSR  = 32;
    localparam int DONE = 64;
    localparam int RET  = 128;
    localparam int BR   = 256;
    localparam int TRAP = 512;

    typedef struct {
        bit       rst, valid, u1, u2, wr, lng, csr, done, ret, br, trap;
        bit [4:0] rs1, rs2, rd, lrd;
    } in_t;

    typedef struct {
        in_t       x;
        bit [4:0]  st, fl;
        bit        k;
        bit [31:0] busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hdu_sb_if #(.NUM_STAGES(NS), .NREG(NR), .RAW(RW)) bus ();

    hdu_sb #(
        .NUM_STAGES(NS), .ID_STAGE(1), .BRANCH_STAGE(2),
        .NREG(NR), .RAW(RW), .LU_DEPTH(LD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int        n_checks = 0;
    int        n_errors = 0;
    vec_t      tbl[$];
    bit [31:0] m_busy;
    int        m_cnt;
    bit        m_drain;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk_in(input int f, input bit [4:0] rs1, input bit [4:0] rd,
                                  input bit [4:0] lrd);
        in_t x;
        x.rst = (f & RST) != 0;   x.valid = (f & VAL) != 0;  x.u1 = (f & U1) != 0;
        x.u2 = 1'b0;              x.wr = (f & WR) != 0;      x.lng = (f & LNG) != 0;
        x.csr = (f & CSR) != 0;   x.done = (f & DONE) != 0;  x.ret = (f & RET) != 0;
        x.br = (f & BR) != 0;     x.trap = (f & TRAP) != 0;
        x.rs1 = rs1; x.rs2 = 5'd0; x.rd = rd; x.lrd = lrd;
        return x;
    endfunction

    task automatic add(input int f, input bit [4:0] rs1, input bit [4:0] rd, input bit [4:0] lrd,
                       input bit [4:0] st, input bit [4:0] fl, input bit k, input bit [31:0] busy);
        vec_t v;
        v.x = mk_in(f, rs1, rd, lrd);
        v.st = st; v.fl = fl; v.k = k; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t x);
        rst             = x.rst;
        bus.id_valid    = x.valid;  bus.id_rs1 = x.rs1;  bus.id_rs2 = x.rs2;
        bus.id_rs1_used = x.u1;     bus.id_rs2_used = x.u2;
        bus.id_rd       = x.rd;     bus.id_rd_write = x.wr;
        bus.id_long_lat = x.lng;    bus.id_csr = x.csr;
        bus.lat_done    = x.done;   bus.lat_rd = x.lrd;
        bus.csr_retire  = x.ret;    bus.branch_take = x.br;  bus.trap_take = x.trap;
    endtask

    // Expected outputs from the hazard rules applied to the model state.
    function automatic void model_exp(input in_t x, output bit [4:0] st, output bit [4:0] fl,
                                      output bit k, output bit iss);
        bit [31:0] avail;
        bit        hold;
        avail = ~m_busy;
        if (x.done) avail[x.lrd] = 1'b1;
        hold = (x.valid && ((x.u1 && !avail[x.rs1]) || (x.u2 && !avail[x.rs2]) ||
                            (x.wr && !avail[x.rd])))
            || (x.valid && x.lng && m_cnt == LD && !x.done)
            || m_drain || (x.valid && x.csr && m_cnt != 0);
        iss = x.valid && !hold && !x.br && !x.trap;
        st = 5'd0; fl = 5'd0; k = 1'b0;
        if (x.rst) fl = 5'b11111;
        else if (x.trap) begin fl = 5'b11111; k = 1'b1; end
        else if (x.br) fl = 5'b00011;
        else if (hold) begin st = 5'b00001; fl = 5'b00010; end
    endfunction

    task automatic model_update(input in_t x, input bit iss);
        int old;
        if (x.rst || x.trap) begin
            m_busy = '0; m_cnt = 0; m_drain = 1'b0;
        end else begin
            old = m_cnt;
            if (x.done) m_busy[x.lrd] = 1'b0;
            if (iss && x.lng) begin
                if (x.wr && x.rd != 5'd0) m_busy[x.rd] = 1'b1;
                m_cnt++;
            end
            if (x.done && old > 0) m_cnt--;
            if (m_drain && x.ret) m_drain = 1'b0;
            else if (!m_drain && iss && x.csr) m_drain = 1'b1;
        end
    endtask

    task automatic step_model(input in_t x);
        bit [4:0] st, fl;
        bit       k, iss;
        drive(x);
        #2;
        model_exp(x, st, fl, k, iss);
        check("rnd_stall", 32'(bus.stage_stall), 32'(st));
        check("rnd_flush", 32'(bus.stage_flush), 32'(fl));
        check("rnd_kill",  32'(bus.lu_kill),     32'(k));
        check("rnd_busy",  bus.sb_busy,          m_busy);
        model_update(x, iss);
        @(posedge clk); #1;
    endtask

    initial begin
        in_t z;
        z = mk_in(RST, 5'd0, 5'd0, 5'd0);
        drive(z);
        @(posedge clk); @(posedge clk); #1;
        m_busy = '0; m_cnt = 0; m_drain = 1'b0;

        // load-use
        add(RST,            0,  0, 0, 5'b00000, 5'b11111, 0, 32'h0);
        add(VAL|LNG|WR,     0,  5, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(VAL|U1,         5,  6, 0, 5'b00001, 5'b00010, 0, 32'h20);
        add(VAL|U1,         5,  6, 0, 5'b00001, 5'b00010, 0, 32'h20);
        add(VAL|U1|DONE,    5,  6, 5, 5'b00000, 5'b00000, 0, 32'h20);
        // structural limit
        add(VAL|LNG|WR,     0,  3, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(VAL|LNG|WR,     0,  4, 0, 5'b00000, 5'b00000, 0, 32'h8);
        add(VAL|LNG|WR,     0,  6, 0, 5'b00001, 5'b00010, 0, 32'h18);
        add(VAL|LNG|WR|DONE,0,  6, 3, 5'b00000, 5'b00000, 0, 32'h18);
        // branch over hazard, then trap with writeback
        add(VAL|U1|BR,      4,  0, 0, 5'b00000, 5'b00011, 0, 32'h50);
        add(VAL|U1|TRAP|DONE,6, 0, 4, 5'b00000, 5'b11111, 1, 32'h50);
        // CSR drain
        add(VAL|U1|CSR,     6,  0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(VAL,            0,  0, 0, 5'b00001, 5'b00010, 0, 32'h0);
        add(VAL,            0,  0, 0, 5'b00001, 5'b00010, 0, 32'h0);
        add(VAL|RET,        0,  0, 0, 5'b00001, 5'b00010, 0, 32'h0);
        add(VAL,            0,  0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        // WAW and x0
        add(VAL|LNG|WR,     0,  0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(VAL|LNG|WR,     0,  7, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(VAL|WR|DONE,    0,  7, 0, 5'b00001, 5'b00010, 0, 32'h80);
        add(VAL|WR|DONE,    0,  7, 7, 5'b00000, 5'b00000, 0, 32'h80);
        // CSR waits for outstanding op
        add(VAL|LNG|WR,     0,  9, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(VAL|CSR,        0,  0, 0, 5'b00001, 5'b00010, 0, 32'h200);
        add(VAL|CSR|DONE,   0,  0, 9, 5'b00001, 5'b00010, 0, 32'h200);
        add(VAL|CSR,        0,  0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(0,              0,  0, 0, 5'b00001, 5'b00010, 0, 32'h0);
        add(RET,            0,  0, 0, 5'b00001, 5'b00010, 0, 32'h0);
        add(0,              0,  0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        // reset in DRAIN with a busy register
        add(VAL|LNG|WR,     0, 10, 0, 5'b00000, 5'b00000, 0, 32'h0);
        add(VAL|CSR|DONE,   0,  0, 11,5'b00001, 5'b00010, 0, 32'h400);
        add(VAL|CSR,        0,  0, 0, 5'b00000, 5'b00000, 0, 32'h400);
        add(RST,            0,  0, 0, 5'b00000, 5'b11111, 0, 32'h400);
        add(VAL|U1,        10,  0, 0, 5'b00000, 5'b00000, 0, 32'h0);

        foreach (tbl[i]) begin
            bit [4:0] st, fl;
            bit       k, iss;
            drive(tbl[i].x);
            #2;
            check($sformatf("t%0d_stall", i), 32'(bus.stage_stall), 32'(tbl[i].st));
            check($sformatf("t%0d_flush", i), 32'(bus.stage_flush), 32'(tbl[i].fl));
            check($sformatf("t%0d_kill", i),  32'(bus.lu_kill),     32'(tbl[i].k));
            check($sformatf("t%0d_busy", i),  bus.sb_busy,          tbl[i].busy);
            model_exp(tbl[i].x, st, fl, k, iss);
            model_update(tbl[i].x, iss);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 2000; n++) begin
            in_t x;
            x.rst   = ($urandom_range(99) < 1);
            x.valid = ($urandom_range(99) < 70);
            x.u1    = $urandom_range(1);
            x.u2    = $urandom_range(1);
            x.wr    = ($urandom_range(99) < 60);
            x.lng   = ($urandom_range(99) < 35);
            x.csr   = ($urandom_range(99) < 8);
            x.done  = (m_cnt > 0) && ($urandom_range(99) < 45);
            x.ret   = m_drain && ($urandom_range(99) < 30);
            x.br    = ($urandom_range(99) < 6);
            x.trap  = ($urandom_range(99) < 2);
            x.rs1   = 5'($urandom_range(7));
            x.rs2   = 5'($urandom_range(7));
            x.rd    = 5'($urandom_range(7));
            x.lrd   = 5'($urandom_range(7));
            step_model(x);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
